// File: rtl/mvp_fll_seq_if.sv
// Link between mvp_fll_seq and mvp_fll: enable and band-start control out, lock status back.
// The sequencer uses the master modport and the FLL side uses the slave modport.
`timescale 1ns/1ps
interface mvp_fll_seq_if;
   logic       fll_enable;
   logic [5:0] fll_band_start;
   logic       fll_locked;

   modport master (output fll_enable, output fll_band_start, input fll_locked);
   modport slave  (input fll_enable, input fll_band_start, output fll_locked);
endinterface

// File: rtl/mvp_fll_seq.sv
// refclk-domain lock sequencer for mvp_fll: timed attempts, band-stepped retries, pass/fail irq.
// Optional macro MVP_FLL_SEQ_LOCK_TIMER_EN builds the lock_time capture register.
//
// state      | meaning
// -----------+-------------------------------------------------
// IDLE       | FLL off, band preloaded from swi_band_start
// ENABLE     | fll_enable just raised, attempt timer restarted
// WAIT_LOCK  | waiting for fll_locked, bounded by swi_timeout
// RETRY_CHK  | attempt failed; fail out or step band and retry
// GAP        | fll_enable held low before the next attempt
// DONE       | locked, lock_ok high, watching for loss of lock
// FAIL       | retries exhausted, lock_fail high until start drops
`timescale 1ns/1ps
module mvp_fll_seq #(
   parameter int TIMEOUT_WIDTH = 16,
   parameter int RETRY_WIDTH   = 3
) (
   input  logic                     refclk,
   input  logic                     refclk_reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [TIMEOUT_WIDTH-1:0] swi_timeout,
   input  logic [RETRY_WIDTH-1:0]   swi_max_retries,
   input  logic [5:0]               swi_band_start,
   input  logic [5:0]               swi_band_step,
   input  logic [3:0]               swi_restart_gap,
   mvp_fll_seq_if.master            fll,
   output logic                     busy,
   output logic                     lock_ok,
   output logic                     lock_fail,
   output logic                     lock_lost,
   output logic [RETRY_WIDTH-1:0]   retry_count,
   output logic                     irq,
   output logic [TIMEOUT_WIDTH-1:0] lock_time
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_ENABLE    = 3'd1;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd2;
   localparam logic [2:0] ST_RETRY_CHK = 3'd3;
   localparam logic [2:0] ST_GAP       = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;
   localparam logic [2:0] ST_FAIL      = 3'd6;

   logic [2:0]               state;
   logic [2:0]               state_nxt;
   logic [TIMEOUT_WIDTH-1:0] timer;
   logic [4:0]               gap_cnt;
   logic [5:0]               band;
   logic                     fll_enable;
   logic [6:0]               band_sum;
   logic [5:0]               band_nxt;
   logic                     timeout_hit;
   logic                     retries_spent;
   logic                     enter_done;
   logic                     enter_fail;

   assign fll.fll_enable     = fll_enable;
   assign fll.fll_band_start = band;

   assign band_sum = {1'b0, band} + {1'b0, swi_band_step};
   assign band_nxt = band_sum[6] ? 6'h3f : band_sum[5:0];

   // timer counts refclk cycles since fll_enable rose (ENABLE cycle included),
   // so a zero timeout expires after the first WAIT_LOCK cycle
   assign timeout_hit   = (timer >= swi_timeout);
   assign retries_spent = (retry_count == swi_max_retries);
   assign enter_done    = (state_nxt == ST_DONE) && (state != ST_DONE);
   assign enter_fail    = (state_nxt == ST_FAIL) && (state != ST_FAIL);

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (start) state_nxt = ST_ENABLE;
         ST_ENABLE:    state_nxt = ST_WAIT_LOCK;
         ST_WAIT_LOCK: begin
            if (fll.fll_locked)   state_nxt = ST_DONE;
            else if (timeout_hit) state_nxt = ST_RETRY_CHK;
         end
         ST_RETRY_CHK: state_nxt = retries_spent ? ST_FAIL : ST_GAP;
         ST_GAP:       if (gap_cnt == 5'd0) state_nxt = ST_ENABLE;
         ST_DONE: begin
            if (!start)               state_nxt = ST_IDLE;
            else if (!fll.fll_locked) state_nxt = ST_RETRY_CHK;
         end
         ST_FAIL:      if (!start) state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   always_ff @(posedge refclk or posedge refclk_reset) begin
      if (refclk_reset) begin
         state       <= ST_IDLE;
         fll_enable  <= 1'b0;
         busy        <= 1'b0;
         lock_ok     <= 1'b0;
         lock_fail   <= 1'b0;
         lock_lost   <= 1'b0;
         irq         <= 1'b0;
         retry_count <= '0;
         band        <= 6'd0;
      end else begin
         state      <= state_nxt;
         fll_enable <= (state_nxt == ST_ENABLE) || (state_nxt == ST_WAIT_LOCK) ||
                       (state_nxt == ST_DONE);
         busy       <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE) &&
                       (state_nxt != ST_FAIL);
         lock_ok    <= (state_nxt == ST_DONE);
         lock_fail  <= (state_nxt == ST_FAIL);
         irq        <= enter_done || enter_fail;
         if (state_nxt == ST_IDLE) begin
            retry_count <= '0;
            lock_lost   <= 1'b0;
            band        <= swi_band_start;
         end else if ((state == ST_RETRY_CHK) && (state_nxt == ST_GAP)) begin
            retry_count <= retry_count + RETRY_WIDTH'(1);
            band        <= band_nxt;
         end
         if ((state == ST_DONE) && (state_nxt == ST_RETRY_CHK)) lock_lost <= 1'b1;
      end
   end

   // gap_cnt is a down-counter; GAP plus the RETRY_CHK cycle give 4+swi_restart_gap low cycles
   always_ff @(posedge refclk or posedge refclk_reset) begin
      if (refclk_reset) begin
         timer   <= '0;
         gap_cnt <= 5'd0;
      end else begin
         if ((state_nxt == ST_ENABLE) || (state_nxt == ST_IDLE) || (state_nxt == ST_GAP))
            timer <= '0;
         else if (((state == ST_ENABLE) || (state == ST_WAIT_LOCK)) && (timer != '1))
            timer <= timer + TIMEOUT_WIDTH'(1);

         if (state == ST_RETRY_CHK)
            gap_cnt <= {1'b0, swi_restart_gap} + 5'd2;
         else if ((state == ST_GAP) && (gap_cnt != 5'd0))
            gap_cnt <= gap_cnt - 5'd1;
      end
   end

`ifdef MVP_FLL_SEQ_LOCK_TIMER_EN
   logic [TIMEOUT_WIDTH-1:0] lock_time_q;

   always_ff @(posedge refclk or posedge refclk_reset) begin
      if (refclk_reset)
         lock_time_q <= '0;
      else if ((state_nxt == ST_ENABLE) || (state_nxt == ST_IDLE))
         lock_time_q <= '0;
      else if ((state == ST_WAIT_LOCK) && (state_nxt == ST_DONE))
         lock_time_q <= timer;
   end

   assign lock_time = lock_time_q;
`else
   assign lock_time = '0;
`endif

endmodule

// File: doc/mvp_fll_seq.md
Name: mvp_fll_seq

Overview:
- refclk-domain sequencer directly upstream of mvp_fll: drives its `enable` and `swi_vco_band_start`, and watches its `locked` output.
- Bounds each lock attempt with a timeout. On timeout or loss of lock it retries with a stepped band start, then reports pass/fail to software and raises an interrupt pulse.
- FLL `locked` is generated in the refclk domain, so no synchronizer is needed on it.

Parameters:
- TIMEOUT_WIDTH, 16, width of per-attempt refclk timeout counter
- RETRY_WIDTH, 3, width of retry counter / max-retry field

Ports:
- refclk  in  1  reference clock, shared with mvp_fll
- refclk_reset  in  1  asynchronous active-high reset
- start  in  1  level request; sampled in IDLE
- abort  in  1  level; forces shutdown from any state
- swi_timeout  in  TIMEOUT_WIDTH  refclk cycles allowed per attempt
- swi_max_retries  in  RETRY_WIDTH  retries after first attempt
- swi_band_start  in  6  initial band start
- swi_band_step  in  6  band increment applied per retry
- swi_restart_gap  in  4  extra low cycles on fll_enable between attempts
- fll_locked  in  1  from mvp_fll locked
- fll_enable  out  1  to mvp_fll enable
- fll_band_start  out  6  to mvp_fll swi_vco_band_start
- busy  out  1  high in any state except IDLE, DONE, FAIL
- lock_ok  out  1  high in DONE
- lock_fail  out  1  high in FAIL
- lock_lost  out  1  sticky; set on loss of lock after DONE
- retry_count  out  RETRY_WIDTH  retries consumed this run
- irq  out  1  one-cycle pulse on entry to DONE or FAIL
- lock_time  out  TIMEOUT_WIDTH  cycles from fll_enable rise to lock (see Optional Feature)

Behaviour:
- Reset values: all outputs 0, except fll_band_start = 0. State = IDLE. Timer = 0.
- All outputs are registered. Each takes its new value on the clock edge that enters the state.
- IDLE: retry_count←0, lock_lost←0, fll_band_start←swi_band_start. If start & ~abort → ENABLE.
- ENABLE: fll_enable←1, timer←0 → WAIT_LOCK. Lasts exactly 1 cycle.
- WAIT_LOCK:
  - timer increments each cycle, saturating at all-ones.
  - If fll_locked → DONE. fll_locked wins over a timeout in the same cycle.
  - Else if timer == swi_timeout → fll_enable←0, then RETRY_CHK.
- RETRY_CHK (1 cycle):
  - If retry_count == swi_max_retries → FAIL.
  - Else retry_count+1, fll_band_start←min(fll_band_start+swi_band_step, 63), computed at 7 bits and saturated, timer←0 → GAP.
- GAP: fll_enable held 0 for 4+swi_restart_gap cycles → ENABLE. The minimum of 4 covers the FLL 2-flop enable sync plus its CLK_EXIT state.
- DONE: fll_enable stays 1, lock_ok=1. If fll_locked falls: lock_lost←1, fll_enable←0, → RETRY_CHK. lock_ok clears on leaving DONE.
- FAIL: fll_enable=0, lock_fail=1. When start=0 → IDLE.
- DONE also exits to IDLE when start=0; fll_enable←0 on that edge.
- abort high in any state: next state IDLE, fll_enable←0. irq is not pulsed. abort overrides all other transitions.
- swi_timeout=0: each attempt times out after 1 WAIT_LOCK cycle unless fll_locked is already high.
- swi_max_retries=0: a single attempt, no GAP.
- swi_* inputs are quasi-static and may change only in IDLE.
- A reset asserted mid-operation returns the block to reset values immediately; fll_enable drops asynchronously.

Optional Feature:
- Macro: MVP_FLL_SEQ_LOCK_TIMER_EN.
- Defined:
  - lock_time←timer value on the edge that enters DONE; held until the next ENABLE.
  - lock_time clears to 0 on ENABLE and on entering IDLE.
- Undefined: lock_time tied to 0 and no capture register is built. The port exists in both builds.

Test Plan:
- start=1, swi_timeout=100, fll_locked rises 40 cycles after fll_enable → DONE, lock_ok=1, irq pulse once, retry_count=0, lock_time=40 with macro (0 without).
- swi_timeout=10, swi_max_retries=2, fll_locked never high → three fll_enable pulses, each 11 cycles high, separated by 4+swi_restart_gap low cycles; fll_band_start sequence swi_band_start, +step, +2·step; then FAIL, lock_fail=1, retry_count=2, irq once.
- swi_band_start=60, swi_band_step=5, forced retry → fll_band_start saturates at 63.
- In DONE, drop fll_locked → lock_lost=1, fll_enable low, retry with incremented band; relock → DONE again, lock_lost still 1.
- abort asserted in WAIT_LOCK and in GAP → IDLE next cycle, fll_enable=0, no irq; fll_locked and timeout asserted in the same cycle → DONE.
- refclk_reset pulsed mid-WAIT_LOCK → all outputs 0 immediately; fresh start behaves as in the first scenario.
